// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: shares the DCache request port between pipeline and store drain
module dcache_req_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    p_req,
  input  logic [ADDR_WIDTH-1:0]   p_addr,
  input  logic                    p_we,
  input  logic [DATA_WIDTH/8-1:0] p_sel,
  input  logic [DATA_WIDTH-1:0]   p_wdata,
  input  logic [2:0]              p_type,
  output logic                    p_ack,
  input  logic                    s_req,
  input  logic                    s_urgent,
  input  logic [ADDR_WIDTH-1:0]   s_addr,
  input  logic [DATA_WIDTH/8-1:0] s_sel,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [2:0]              s_type,
  output logic                    s_ack,
  output logic                    dc_ce,
  output logic [ADDR_WIDTH-1:0]   dc_addr,
  output logic                    dc_we,
  output logic [DATA_WIDTH/8-1:0] dc_sel,
  output logic [DATA_WIDTH-1:0]   dc_data,
  output logic [2:0]              dc_type,
  input  logic                    dc_ready,
  input  logic                    dc_ack,
  output logic [1:0]              owner
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t                  r_state, w_next;
  logic [CW-1:0]           r_starve;
  logic [1:0]              r_owner;
  logic                    r_flushed;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [DATA_WIDTH/8-1:0] r_sel;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [2:0]              r_type;
  logic                    w_p_ok, w_s_win, w_grant, w_done, w_abort;
  // State register
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_next;
  // Arbitration, next state and handshake outputs; a flushing pipeline counts as not requesting
  always_comb begin
    w_p_ok  = p_req & !flush;
    w_s_win = s_req & (s_urgent | (r_starve == CW'(STARVE_LIMIT)) | !w_p_ok);
    w_grant = (r_state == S_IDLE) & (w_s_win | w_p_ok);
    w_done  = dc_ack & (((r_state == S_ISSUE) & dc_ready) | (r_state == S_WAIT));
    w_abort = (r_state == S_ISSUE) & (r_owner == 2'b01) & flush & !dc_ready;
    w_next  = r_state;
    if (r_state == S_IDLE) w_next = w_grant ? S_ISSUE : S_IDLE;
    else if (r_state == S_ISSUE) w_next = dc_ready ? (dc_ack ? S_IDLE : S_WAIT) : (w_abort ? S_IDLE : S_ISSUE);
    else w_next = dc_ack ? S_IDLE : S_WAIT;
    dc_ce = r_state == S_ISSUE;
    p_ack = w_done & (r_owner == 2'b01) & !(r_flushed | flush);
    s_ack = w_done & (r_owner == 2'b10);
  end
  // Latch the winner's payload on grant; owner and flush history live for one transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= 2'b00;
      r_flushed <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_data    <= '0;
      r_type    <= 3'b000;
    end else if (w_grant) begin
      r_owner   <= w_s_win ? 2'b10 : 2'b01;
      r_flushed <= 1'b0;
      r_addr    <= w_s_win ? s_addr : p_addr;
      r_we      <= w_s_win | p_we;
      r_sel     <= w_s_win ? s_sel : p_sel;
      r_data    <= w_s_win ? s_wdata : p_wdata;
      r_type    <= w_s_win ? s_type : p_type;
    end else if (w_next == S_IDLE) begin
      r_owner   <= 2'b00;
      r_flushed <= 1'b0;
    end else begin
      r_flushed <= r_flushed | flush;
    end
  end
  // Anti-starvation count of pipeline grants taken while a store waits; only evaluated in IDLE
  always_ff @(posedge clk) begin
    if (rst) r_starve <= '0;
    else if (r_state == S_IDLE) r_starve <= (!s_req | w_s_win) ? '0 : (w_p_ok ? r_starve + CW'(1) : r_starve);
  end
  assign owner   = r_owner;
  assign dc_addr = r_addr;
  assign dc_we   = r_we;
  assign dc_sel  = r_sel;
  assign dc_data = r_data;
  assign dc_type = r_type;
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb_dcache_req_arbiter: directed scenario checks for dcache_req_arbiter
module tb_dcache_req_arbiter;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic p_req = 1'b0, p_we = 1'b0, s_req = 1'b0, s_urgent = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0, s_addr = '0, s_wdata = '0;
  logic [3:0] p_sel = '0, s_sel = '0;
  logic [2:0] p_type = '0, s_type = '0;
  logic p_ack, s_ack, dc_ce, dc_we;
  logic [31:0] dc_addr, dc_data;
  logic [3:0] dc_sel;
  logic [2:0] dc_type;
  logic dc_ready = 1'b0, dc_ack = 1'b0;
  logic [1:0] owner;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dcache_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .p_req(p_req), .p_addr(p_addr), .p_we(p_we), .p_sel(p_sel), .p_wdata(p_wdata), .p_type(p_type), .p_ack(p_ack),
    .s_req(s_req), .s_urgent(s_urgent), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata), .s_type(s_type), .s_ack(s_ack),
    .dc_ce(dc_ce), .dc_addr(dc_addr), .dc_we(dc_we), .dc_sel(dc_sel), .dc_data(dc_data), .dc_type(dc_type),
    .dc_ready(dc_ready), .dc_ack(dc_ack), .owner(owner));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    checks++; if (dc_ce !== 1'b0) begin failures++; $display("FAIL reset_dc_ce got=%b exp=0", dc_ce); end
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%b exp=00", owner); end
    checks++; if (dc_addr !== 32'h0 || dc_data !== 32'h0 || dc_we !== 1'b0) begin failures++; $display("FAIL reset_payload got=%h/%h/%b exp=0/0/0", dc_addr, dc_data, dc_we); end
    checks++; if (p_ack !== 1'b0 || s_ack !== 1'b0) begin failures++; $display("FAIL reset_acks got=%b%b exp=00", p_ack, s_ack); end
  endtask
  task automatic test_load;
    p_req = 1'b1; p_addr = 32'h1000; p_we = 1'b0; p_sel = 4'hf; p_type = 3'b010;
    settle();
    checks++; if (dc_ce !== 1'b0) begin failures++; $display("FAIL load_c0_ce got=%b exp=0", dc_ce); end
    tick();
    dc_ready = 1'b1;
    settle();
    checks++; if (dc_ce !== 1'b1 || dc_addr !== 32'h1000 || dc_we !== 1'b0) begin failures++; $display("FAIL load_c1 got=ce%b addr%h we%b exp=ce1 addr1000 we0", dc_ce, dc_addr, dc_we); end
    checks++; if (owner !== 2'b01) begin failures++; $display("FAIL load_owner got=%b exp=01", owner); end
    tick();
    dc_ready = 1'b0;
    settle();
    checks++; if (dc_ce !== 1'b0 || p_ack !== 1'b0) begin failures++; $display("FAIL load_c2 got=ce%b ack%b exp=ce0 ack0", dc_ce, p_ack); end
    tick();
    dc_ack = 1'b1;
    settle();
    checks++; if (p_ack !== 1'b1 || s_ack !== 1'b0) begin failures++; $display("FAIL load_c3_ack got=p%b s%b exp=p1 s0", p_ack, s_ack); end
    tick();
    dc_ack = 1'b0; p_req = 1'b0;
    settle();
    checks++; if (owner !== 2'b00 || dc_ce !== 1'b0) begin failures++; $display("FAIL load_idle got=owner%b ce%b exp=00 0", owner, dc_ce); end
  endtask
  task automatic test_both;
    p_req = 1'b1; p_addr = 32'h2000; p_we = 1'b0;
    s_req = 1'b1; s_addr = 32'h3000; s_wdata = 32'hdeadbeef; s_sel = 4'h3; s_type = 3'b001;
    dc_ready = 1'b1; dc_ack = 1'b1;
    tick();
    checks++; if (owner !== 2'b01 || dc_addr !== 32'h2000) begin failures++; $display("FAIL both_first got=owner%b addr%h exp=01 2000", owner, dc_addr); end
    checks++; if (p_ack !== 1'b1 || s_ack !== 1'b0) begin failures++; $display("FAIL both_pack got=p%b s%b exp=p1 s0", p_ack, s_ack); end
    p_req = 1'b0;
    tick();
    checks++; if (owner !== 2'b00 || dc_ce !== 1'b0) begin failures++; $display("FAIL both_idle got=owner%b ce%b exp=00 0", owner, dc_ce); end
    tick();
    checks++; if (owner !== 2'b10 || dc_addr !== 32'h3000 || dc_data !== 32'hdeadbeef || dc_we !== 1'b1 || dc_sel !== 4'h3 || dc_type !== 3'b001) begin failures++; $display("FAIL both_store got=owner%b addr%h data%h we%b sel%h type%b exp=10 3000 deadbeef 1 3 001", owner, dc_addr, dc_data, dc_we, dc_sel, dc_type); end
    checks++; if (s_ack !== 1'b1 || p_ack !== 1'b0) begin failures++; $display("FAIL both_sack got=s%b p%b exp=s1 p0", s_ack, p_ack); end
    s_req = 1'b0; dc_ack = 1'b0; dc_ready = 1'b0;
    tick();
  endtask
  task automatic test_starvation;
    int grants = 0;
    bit seen = 1'b0;
    p_req = 1'b1; p_addr = 32'h4000; s_req = 1'b1; s_addr = 32'h5000;
    dc_ready = 1'b1; dc_ack = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (owner == 2'b01) grants++;
      if (owner == 2'b10) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL starve_store_grant got=none exp=store within 40 cycles"); end
    checks++; if (grants != 8) begin failures++; $display("FAIL starve_count got=%0d exp=8", grants); end
    checks++; if (s_ack !== 1'b1 || dc_addr !== 32'h5000) begin failures++; $display("FAIL starve_sack got=s%b addr%h exp=1 5000", s_ack, dc_addr); end
    tick();
    tick();
    checks++; if (owner !== 2'b01) begin failures++; $display("FAIL starve_cleared got=%b exp=01", owner); end
    p_req = 1'b0; s_req = 1'b0;
    tick();
    dc_ack = 1'b0; dc_ready = 1'b0;
    tick();
  endtask
  task automatic test_urgent;
    p_req = 1'b1; p_addr = 32'h6000; s_req = 1'b1; s_urgent = 1'b1; s_addr = 32'h7000;
    dc_ready = 1'b1;
    tick();
    checks++; if (owner !== 2'b10 || dc_addr !== 32'h7000) begin failures++; $display("FAIL urgent_grant got=owner%b addr%h exp=10 7000", owner, dc_addr); end
    tick();
    dc_ack = 1'b1;
    settle();
    checks++; if (s_ack !== 1'b1 || p_ack !== 1'b0) begin failures++; $display("FAIL urgent_ack got=s%b p%b exp=s1 p0", s_ack, p_ack); end
    tick();
    dc_ack = 1'b0; dc_ready = 1'b0; p_req = 1'b0; s_req = 1'b0; s_urgent = 1'b0;
    tick();
  endtask
  task automatic test_flush;
    p_req = 1'b1; p_addr = 32'h8000;
    tick();
    flush = 1'b1;
    settle();
    checks++; if (dc_ce !== 1'b1 || owner !== 2'b01) begin failures++; $display("FAIL flush_issue got=ce%b owner%b exp=1 01", dc_ce, owner); end
    tick();
    flush = 1'b0; p_req = 1'b0; dc_ack = 1'b1;
    settle();
    checks++; if (dc_ce !== 1'b0 || owner !== 2'b00) begin failures++; $display("FAIL flush_abort got=ce%b owner%b exp=0 00", dc_ce, owner); end
    checks++; if (p_ack !== 1'b0 || s_ack !== 1'b0) begin failures++; $display("FAIL flush_idle_ack got=p%b s%b exp=00", p_ack, s_ack); end
    tick();
    dc_ack = 1'b0;
    p_req = 1'b1; p_addr = 32'h9000; dc_ready = 1'b1;
    tick();
    tick();
    dc_ready = 1'b0; flush = 1'b1;
    settle();
    checks++; if (owner !== 2'b01 || dc_ce !== 1'b0) begin failures++; $display("FAIL flush_wait got=owner%b ce%b exp=01 0", owner, dc_ce); end
    tick();
    flush = 1'b0; dc_ack = 1'b1; p_req = 1'b0;
    settle();
    checks++; if (p_ack !== 1'b0) begin failures++; $display("FAIL flush_wait_ack got=%b exp=0", p_ack); end
    tick();
    dc_ack = 1'b0;
    settle();
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL flush_wait_done got=%b exp=00", owner); end
  endtask
  task automatic test_rst_mid;
    s_req = 1'b1; s_addr = 32'ha000; s_wdata = 32'h12345678; dc_ready = 1'b1;
    tick();
    tick();
    dc_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; s_req = 1'b0;
    settle();
    checks++; if (dc_ce !== 1'b0 || owner !== 2'b00 || dc_addr !== 32'h0 || dc_data !== 32'h0 || dc_we !== 1'b0) begin failures++; $display("FAIL rst_mid got=ce%b owner%b addr%h data%h we%b exp=all 0", dc_ce, owner, dc_addr, dc_data, dc_we); end
    tick();
    dc_ack = 1'b1;
    settle();
    checks++; if (p_ack !== 1'b0 || s_ack !== 1'b0) begin failures++; $display("FAIL rst_late_ack got=p%b s%b exp=00", p_ack, s_ack); end
    tick();
    dc_ack = 1'b0;
  endtask
  initial begin
    test_reset();
    test_load();
    test_both();
    test_starvation();
    test_urgent();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
